// File: rtl/g4_chain_search_ctrl_if.sv
// ----------------------------------------------------------------------------
// g4_chain_search_ctrl_if
// Bundles the request, response and table-unit signals of the G4 chain search
// controller.
//   slave  : controller side (accepts requests, produces responses, drives
//            the table probe and consumes the table results)
//   master : environment side (dispatcher, response consumer and table unit)
// Signals:
//   req_valid/req_ready/req_head_index/req_tuple   request handshake
//   rsp_valid/rsp_ready/rsp_match/rsp_ruleID/
//   rsp_hops/rsp_timeout                           response handshake
//   tbl_search_index/tbl_tupleData                 probe towards table unit
//   tbl_match/tbl_ruleID/tbl_next_index            table unit results
// ----------------------------------------------------------------------------
interface g4_chain_search_ctrl_if;
    logic         req_valid;
    logic         req_ready;
    logic [10:0]  req_head_index;
    logic [103:0] req_tuple;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_match;
    logic [10:0]  rsp_ruleID;
    logic [5:0]   rsp_hops;
    logic         rsp_timeout;

    logic [10:0]  tbl_search_index;
    logic [103:0] tbl_tupleData;
    logic         tbl_match;
    logic [10:0]  tbl_ruleID;
    logic [10:0]  tbl_next_index;

    modport slave (
        input  req_valid, req_head_index, req_tuple, rsp_ready,
               tbl_match, tbl_ruleID, tbl_next_index,
        output req_ready, rsp_valid, rsp_match, rsp_ruleID, rsp_hops,
               rsp_timeout, tbl_search_index, tbl_tupleData
    );

    modport master (
        output req_valid, req_head_index, req_tuple, rsp_ready,
               tbl_match, tbl_ruleID, tbl_next_index,
        input  req_ready, rsp_valid, rsp_match, rsp_ruleID, rsp_hops,
               rsp_timeout, tbl_search_index, tbl_tupleData
    );
endinterface

// File: rtl/g4_chain_search_ctrl.sv
// ----------------------------------------------------------------------------
// g4_chain_search_ctrl
// Sequencer for one G4 tuple-table search unit. Accepts a lookup request
// (104-bit tuple + chain head index), walks the linked entry chain by feeding
// each returned next-index back as the search index, and reports the first
// matching ruleID (or, with G4_CTRL_BEST_MATCH_EN defined, the smallest
// matching ruleID over the whole walk).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    g4_chain_search_ctrl_if.slave (request, response, table probe)
// Parameters:
//   RD_LATENCY  table read latency in cycles (1..4)
//   NULL_INDEX  next-index value terminating a chain
//   MAX_HOPS    maximum entries visited per request (1..63)
// Optional macro:
//   G4_CTRL_BEST_MATCH_EN  keep walking after a match, report lowest ruleID
// ----------------------------------------------------------------------------
module g4_chain_search_ctrl #(
    parameter int unsigned RD_LATENCY = 2,
    parameter logic [10:0] NULL_INDEX = 11'h7FF,
    parameter int unsigned MAX_HOPS   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    g4_chain_search_ctrl_if.slave   bus
);

    localparam logic [1:0] WAIT_INIT  = 2'(RD_LATENCY - 1);
    localparam logic [5:0] MAX_HOPS_V = 6'(MAX_HOPS);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, RESP} state_t;

    state_t        state_q, state_d;
    logic [10:0]   idx_q, idx_d;
    logic [103:0]  tuple_q, tuple_d;
    logic [5:0]    hops_q, hops_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic          match_q, match_d;
    logic [10:0]   rule_q, rule_d;
    logic          tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= NULL_INDEX;
            tuple_q <= '0;
            hops_q  <= '0;
            wcnt_q  <= '0;
            match_q <= 1'b0;
            rule_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tuple_q <= tuple_d;
            hops_q  <= hops_d;
            wcnt_q  <= wcnt_d;
            match_q <= match_d;
            rule_q  <= rule_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tuple_d = tuple_q;
        hops_d  = hops_q;
        wcnt_d  = wcnt_q;
        match_d = match_q;
        rule_d  = rule_q;
        tmo_d   = tmo_q;

        case (state_q)
            IDLE: begin
                // req_ready is high throughout IDLE, so req_valid alone completes the handshake
                if (bus.req_valid) begin
                    tuple_d = bus.req_tuple;
                    idx_d   = bus.req_head_index;
                    hops_d  = '0;
                    match_d = 1'b0;
                    rule_d  = '0;
                    tmo_d   = 1'b0;
                    state_d = (bus.req_head_index == NULL_INDEX) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (hops_q != MAX_HOPS_V) begin
                    hops_d = hops_q + 6'd1;
                end
                wcnt_d  = WAIT_INIT;
                // With a single-cycle table there are no WAIT cycles at all
                state_d = (RD_LATENCY > 1) ? WAIT : CHECK;
            end
            WAIT: begin
                wcnt_d = wcnt_q - 2'd1;
                if (wcnt_q <= 2'd1) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
`ifdef G4_CTRL_BEST_MATCH_EN
                if (bus.tbl_match && (!match_q || (bus.tbl_ruleID < rule_q))) begin
                    match_d = 1'b1;
                    rule_d  = bus.tbl_ruleID;
                end
                if (bus.tbl_next_index == NULL_INDEX) begin
                    state_d = RESP;
                end else if (hops_q == MAX_HOPS_V) begin
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    idx_d   = bus.tbl_next_index;
                    state_d = ISSUE;
                end
`else
                if (bus.tbl_match) begin
                    match_d = 1'b1;
                    rule_d  = bus.tbl_ruleID;
                    state_d = RESP;
                end else if (bus.tbl_next_index == NULL_INDEX) begin
                    state_d = RESP;
                end else if (hops_q == MAX_HOPS_V) begin
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    idx_d   = bus.tbl_next_index;
                    state_d = ISSUE;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rule_q is cleared on accept and only loaded on a match, so it reads 0
    // for every non-matching response
    assign bus.req_ready        = (state_q == IDLE);
    assign bus.rsp_valid        = (state_q == RESP);
    assign bus.rsp_match        = match_q;
    assign bus.rsp_ruleID       = rule_q;
    assign bus.rsp_hops         = hops_q;
    assign bus.rsp_timeout      = tmo_q;
    assign bus.tbl_search_index = idx_q;
    assign bus.tbl_tupleData    = tuple_q;

endmodule

// File: tb/tb_g4_chain_search_ctrl.sv
// ----------------------------------------------------------------------------
// tb_g4_chain_search_ctrl
// Self-checking bench for g4_chain_search_ctrl. A small table-unit model
// answers probes after RD_LATENCY cycles; expected responses come from a
// chain-walking reference function over the same table contents.
// ----------------------------------------------------------------------------
module tb_g4_chain_search_ctrl;

    localparam int unsigned RD   = 2;
    localparam int unsigned MAXH = 32;
    localparam logic [10:0] NULLI = 11'h7FF;

    logic clk;
    logic rst_n;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    g4_chain_search_ctrl_if bus();

    g4_chain_search_ctrl #(
        .RD_LATENCY (RD),
        .NULL_INDEX (NULLI),
        .MAX_HOPS   (MAXH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- table unit model ----------------
    logic [103:0] key_mem  [2048];
    logic [10:0]  rule_mem [2048];
    logic [10:0]  nxt_mem  [2048];
    logic [10:0]  idx_pipe [4];
    logic [103:0] tup_pipe [4];

    always @(posedge clk) begin
        idx_pipe[0] <= bus.tbl_search_index;
        tup_pipe[0] <= bus.tbl_tupleData;
        for (int i = 1; i < 4; i++) begin
            idx_pipe[i] <= idx_pipe[i-1];
            tup_pipe[i] <= tup_pipe[i-1];
        end
    end

    assign bus.tbl_match      = (key_mem[idx_pipe[RD-1]] === tup_pipe[RD-1]);
    assign bus.tbl_ruleID     = rule_mem[idx_pipe[RD-1]];
    assign bus.tbl_next_index = nxt_mem[idx_pipe[RD-1]];

    // ---------------- reference walk ----------------
    function automatic void model(input logic [10:0] head, input logic [103:0] tup,
                                  output bit m, output logic [10:0] r,
                                  output int unsigned h, output bit t,
                                  output logic [10:0] last);
        logic [10:0] idx;
        idx = head; m = 0; r = '0; h = 0; t = 0; last = head;
        if (head == NULLI) return;
        for (int unsigned k = 0; k < 100; k++) begin
            h++;
            last = idx;
`ifdef G4_CTRL_BEST_MATCH_EN
            if (key_mem[idx] == tup && (!m || rule_mem[idx] < r)) begin
                m = 1; r = rule_mem[idx];
            end
`else
            if (key_mem[idx] == tup) begin
                m = 1; r = rule_mem[idx];
                return;
            end
`endif
            if (nxt_mem[idx] == NULLI) return;
            if (h == MAXH) begin
                t = 1;
                return;
            end
            idx = nxt_mem[idx];
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic start_req(input logic [10:0] head, input logic [103:0] tup);
        int unsigned n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_before_accept", bus.req_ready, 1'b1);
        bus.req_valid      = 1'b1;
        bus.req_head_index = head;
        bus.req_tuple      = tup;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int unsigned want_lat);
        int unsigned cnt = 1;
        while (bus.rsp_valid !== 1'b1 && cnt < 400) begin
            @(posedge clk); #1; cnt++;
        end
        chk("latency", cnt, want_lat);
    endtask

    task automatic check_fields(input bit m, input logic [10:0] r, input int unsigned h,
                                input bit t, input logic [10:0] last, input logic [103:0] tup);
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_match", bus.rsp_match, m);
        chk("rsp_ruleID", bus.rsp_ruleID, r);
        chk("rsp_hops", bus.rsp_hops, h);
        chk("rsp_timeout", bus.rsp_timeout, t);
        chk("tbl_search_index", bus.tbl_search_index, last);
        chk("tbl_tupleData", bus.tbl_tupleData, tup);
        chk("req_ready_in_resp", bus.req_ready, 1'b0);
    endtask

    task automatic hold_and_ack(input bit m, input logic [10:0] r, input int unsigned h,
                                input bit t, input logic [10:0] last, input logic [103:0] tup,
                                input int unsigned hold);
        check_fields(m, r, h, t, last, tup);
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_fields(m, r, h, t, last, tup);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_ack", bus.rsp_valid, 1'b0);
        chk("req_ready_after_ack", bus.req_ready, 1'b1);
    endtask

    function automatic int unsigned lat_of(input int unsigned h);
        return (h == 0) ? 1 : h * (RD + 1) + 1;
    endfunction

    task automatic run_txn(input logic [10:0] head, input logic [103:0] tup, input int unsigned hold);
        bit m, t;
        logic [10:0] r, last;
        int unsigned h;
        model(head, tup, m, r, h, t, last);
        start_req(head, tup);
        wait_rsp(lat_of(h));
        hold_and_ack(m, r, h, t, last, tup, hold);
    endtask

    function automatic logic [103:0] rnd_tuple();
        return {$urandom, $urandom, $urandom, 8'($urandom)};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [103:0] tup, tupb;
        logic [10:0]  nodes [8];
        logic [10:0]  head;
        bit m, t, mb, tb2;
        logic [10:0] r, last, rb, lastb;
        int unsigned h, hb, len;

        for (int i = 0; i < 2048; i++) begin
            key_mem[i] = '0; rule_mem[i] = '0; nxt_mem[i] = NULLI;
        end
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.req_head_index = '0; bus.req_tuple = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_match", bus.rsp_match, 1'b0);
        chk("rst_rsp_ruleID", bus.rsp_ruleID, 11'd0);
        chk("rst_rsp_hops", bus.rsp_hops, 6'd0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
        chk("rst_tbl_index", bus.tbl_search_index, NULLI);
        chk("rst_tbl_tuple", bus.tbl_tupleData, 104'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // chain 5 -> 9 -> NULL, entry 9 matches with 0x123
        tup = rnd_tuple();
        key_mem[5] = ~tup; rule_mem[5] = 11'h055; nxt_mem[5] = 11'd9;
        key_mem[9] = tup;  rule_mem[9] = 11'h123; nxt_mem[9] = NULLI;
        start_req(11'd5, tup);
        wait_rsp(2 * (RD + 1) + 1);
        hold_and_ack(1'b1, 11'h123, 2, 1'b0, 11'd9, tup, 0);

        // NULL head
        run_txn(NULLI, rnd_tuple(), 1);

        // chain 3 -> 4 -> NULL, no match
        tup = rnd_tuple();
        key_mem[3] = ~tup; rule_mem[3] = 11'h3A1; nxt_mem[3] = 11'd4;
        key_mem[4] = ~tup; rule_mem[4] = 11'h2B2; nxt_mem[4] = NULLI;
        start_req(11'd3, tup);
        wait_rsp(2 * (RD + 1) + 1);
        hold_and_ack(1'b0, 11'd0, 2, 1'b0, 11'd4, tup, 0);

        // self-loop 7 -> 7, no match: timeout at MAX_HOPS
        tup = rnd_tuple();
        key_mem[7] = ~tup; rule_mem[7] = 11'h777; nxt_mem[7] = 11'd7;
        start_req(11'd7, tup);
        wait_rsp(MAXH * (RD + 1) + 1);
        hold_and_ack(1'b0, 11'd0, MAXH, 1'b1, 11'd7, tup, 0);

        // exactly MAX_HOPS entries ending in NULL (no timeout), then MAX_HOPS+1
        tup = rnd_tuple();
        for (int i = 0; i < 33; i++) begin
            key_mem[100+i] = ~tup; rule_mem[100+i] = 11'(i);
            nxt_mem[100+i] = (i == 31) ? NULLI : 11'(101 + i);
        end
        run_txn(11'd100, tup, 0);
        nxt_mem[131] = 11'd132;
        run_txn(11'd100, tup, 0);

        // two matching entries 0x40 then 0x10
        tup = rnd_tuple();
        key_mem[20] = tup; rule_mem[20] = 11'h040; nxt_mem[20] = 11'd21;
        key_mem[21] = tup; rule_mem[21] = 11'h010; nxt_mem[21] = NULLI;
        run_txn(11'd20, tup, 0);

        // response back-pressure with a second request waiting
        tup  = rnd_tuple();
        tupb = rnd_tuple();
        key_mem[30] = ~tup; rule_mem[30] = 11'h001; nxt_mem[30] = 11'd31;
        key_mem[31] = tup;  rule_mem[31] = 11'h5A5; nxt_mem[31] = NULLI;
        key_mem[40] = tupb; rule_mem[40] = 11'h0C3; nxt_mem[40] = NULLI;
        model(11'd30, tup, m, r, h, t, last);
        model(11'd40, tupb, mb, rb, hb, tb2, lastb);
        start_req(11'd30, tup);
        wait_rsp(lat_of(h));
        bus.req_valid = 1'b1; bus.req_head_index = 11'd40; bus.req_tuple = tupb;
        hold_and_ack(m, r, h, t, last, tup, 10);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("second_req_accepted", bus.req_ready, 1'b0);
        wait_rsp(lat_of(hb));
        hold_and_ack(mb, rb, hb, tb2, lastb, tupb, 0);

        // reset during WAIT of hop 2
        tup = rnd_tuple();
        key_mem[50] = ~tup; nxt_mem[50] = 11'd51;
        key_mem[51] = ~tup; nxt_mem[51] = 11'd52;
        key_mem[52] = tup;  rule_mem[52] = 11'h222; nxt_mem[52] = NULLI;
        start_req(11'd50, tup);
        repeat (4) begin @(posedge clk); #1; end
        chk("mid_walk_hops", bus.rsp_hops, 6'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", bus.req_ready, 1'b1);
        chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("midrst_rsp_hops", bus.rsp_hops, 6'd0);
        chk("midrst_tbl_index", bus.tbl_search_index, NULLI);
        chk("midrst_tbl_tuple", bus.tbl_tupleData, 104'd0);
        #2 rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            chk("no_rsp_after_reset", bus.rsp_valid, 1'b0);
        end
        run_txn(11'd50, tup, 2);

        // randomized chains, including loops that run into MAX_HOPS
        for (int it = 0; it < 40; it++) begin
            tup = rnd_tuple();
            len = $urandom_range(1, 8);
            for (int unsigned i = 0; i < len; i++) nodes[i] = 11'($urandom_range(0, 2046));
            for (int unsigned i = 0; i < len; i++) begin
                key_mem[nodes[i]]  = ($urandom_range(0, 3) == 0) ? tup : ~tup;
                rule_mem[nodes[i]] = 11'($urandom);
                if (i + 1 < len)
                    nxt_mem[nodes[i]] = nodes[i+1];
                else
                    nxt_mem[nodes[i]] = ($urandom_range(0, 1) == 1) ? nodes[$urandom_range(0, len - 1)] : NULLI;
            end
            head = ($urandom_range(0, 15) == 0) ? NULLI : nodes[0];
            run_txn(head, tup, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/g4_chain_search_ctrl.md
Name: g4_chain_search_ctrl

Overview:
Sequencer for one G4 tuple-table search unit. It accepts a lookup request carrying a 104-bit tuple and the chain head index. It walks the linked entry chain by feeding each returned next-index back as the search index, then reports the first matching ruleID. The block sits between the subset dispatcher and the table search instance.

Parameters:
RD_LATENCY, 2, cycles from driving tbl_search_index to valid tbl_match/tbl_ruleID/tbl_next_index; legal range 1..4.
NULL_INDEX, 11'h7FF, next-index value that terminates a chain.
MAX_HOPS, 32, maximum entries visited per request before timeout; legal range 1..63.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_head_index  in  11  first entry of the chain.
req_tuple  in  104  {proto[103:96], reserved[95:80], dstPort[79:64], dstIP[63:32], srcIP[31:0]}.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_match  out  1  a rule matched.
rsp_ruleID  out  11  matched rule; 0 when rsp_match=0.
rsp_hops  out  6  entries visited.
rsp_timeout  out  1  MAX_HOPS reached without match or chain end.
tbl_search_index  out  11  index to the table unit.
tbl_tupleData  out  104  tuple to the table unit.
tbl_match  in  1  table compare result for the probed entry.
tbl_ruleID  in  11  table rule ID.
tbl_next_index  in  11  table chain pointer.

Behaviour:
- Reset values (async on rst_n low):
  - req_ready=1; rsp_valid=0; rsp_match=0; rsp_ruleID=0; rsp_hops=0; rsp_timeout=0.
  - tbl_search_index=NULL_INDEX; tbl_tupleData=0.
  - FSM returns to IDLE. Reset mid-walk abandons the request; no response is produced.
- States: IDLE, ISSUE, WAIT, CHECK, RESP.
- IDLE: req_ready=1.
  - On req_valid&req_ready, latch the tuple into tbl_tupleData and the head into tbl_search_index.
  - Clear hop count; go to ISSUE. req_ready drops the next cycle.
  - If req_head_index==NULL_INDEX, go directly to RESP with match=0, hops=0, timeout=0.
- ISSUE: one cycle holding tbl_search_index. Increment the hop count. Load the wait counter with RD_LATENCY-1. Go to WAIT.
- WAIT: decrement the wait counter; at 0 go to CHECK. tbl_search_index and tbl_tupleData stay stable through ISSUE..CHECK.
- CHECK: sample the tbl_* inputs. These are valid only in this cycle; tbl_match outside CHECK is ignored. Evaluate in priority order:
  1. tbl_match=1: rsp_match=1, rsp_ruleID=tbl_ruleID; go to RESP.
  2. tbl_next_index==NULL_INDEX: rsp_match=0; go to RESP.
  3. hops==MAX_HOPS: rsp_timeout=1, rsp_match=0; go to RESP.
  4. Otherwise: tbl_search_index<=tbl_next_index; go to ISSUE.
- Per-hop latency: RD_LATENCY+1 cycles (ISSUE + WAIT states + CHECK).
- RESP: rsp_valid=1, with all rsp_* fields held stable until rsp_ready.
  - On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE; req_ready=1 the next cycle.
  - No request is accepted in the RESP cycle itself, so there is no response/request overlap.
- A self-loop (next_index equal to the current index) is bounded by MAX_HOPS.
- rsp_hops saturates at MAX_HOPS and never wraps.
- When a response is not a match, rsp_ruleID is driven to 0.

Optional Feature:
Macro G4_CTRL_BEST_MATCH_EN.
- Defined: a match in CHECK does not terminate the walk.
  - The controller keeps the smallest matching ruleID seen so far (lower ID = higher priority).
  - It continues until NULL_INDEX or MAX_HOPS.
  - rsp_match=1 if any entry matched. On timeout with at least one match, rsp_match=1 and rsp_timeout=1.
- Undefined: first match terminates the walk, as described in Behaviour.

Test Plan:
- Head=5, table chain 5->9->NULL, entry 9 matches ruleID=0x123 -> rsp_valid after 2*(RD_LATENCY+1)+1 cycles from accept; rsp_match=1, ruleID=0x123, hops=2, timeout=0.
- Head=NULL_INDEX -> rsp_valid the cycle after accept; match=0, hops=0, timeout=0.
- Chain 3->4->NULL, no match -> match=0, ruleID=0, hops=2, timeout=0.
- Self-loop 7->7, no match, MAX_HOPS=32 -> timeout=1, hops=32, match=0; tbl_search_index stays 7.
- rsp_ready held low 10 cycles, then a second req_valid -> rsp fields stable throughout, req_ready=0 until the cycle after the handshake, second request accepted then.
- Assert rst_n low during WAIT of hop 2 -> all outputs return to reset values immediately; next request is processed correctly. With G4_CTRL_BEST_MATCH_EN, chain matching ruleIDs 0x40 then 0x10 -> ruleID=0x10.
